// File: rtl/sprite_pixel_compositor_if.sv
// Sprite ROM port bundle: read addresses and Pac-Man image select out,
// 24-bit pixel data back one cycle later.
interface sprite_pixel_compositor_if;
    logic [9:0]  pac_man_cut_read_address;
    logic [9:0]  pac_man_full_read_address_special;
    logic [9:0]  red_evil_read_address;
    logic [9:0]  blue_evil_read_address;
    logic [9:0]  green_evil_read_address;
    logic [2:0]  direction;
    logic [23:0] pac_man_cut_data_out;
    logic [23:0] red_evil_data_out;
    logic [23:0] blue_evil_data_out;
    logic [23:0] green_evil_data_out;

    modport master (
        output pac_man_cut_read_address, pac_man_full_read_address_special,
               red_evil_read_address, blue_evil_read_address,
               green_evil_read_address, direction,
        input  pac_man_cut_data_out, red_evil_data_out,
               blue_evil_data_out, green_evil_data_out
    );

    modport slave (
        input  pac_man_cut_read_address, pac_man_full_read_address_special,
               red_evil_read_address, blue_evil_read_address,
               green_evil_read_address, direction,
        output pac_man_cut_data_out, red_evil_data_out,
               blue_evil_data_out, green_evil_data_out
    );
endinterface

// File: rtl/sprite_pixel_compositor.sv
// Sprite ROM addressing, Pac-Man animation select and two-stage colour-key
// compositor over the maze background. Sprite index: 0 pac, 1 red, 2 blue, 3 green.
module sprite_pixel_compositor #(
    parameter int          SPRITE_W    = 26,
    parameter int          SPRITE_H    = 26,
    parameter int          ANIM_FRAMES = 8,
    parameter logic [23:0] KEY_COLOR   = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        pix_valid,
    input  logic [23:0] background_rgb,
    input  logic [9:0]  pac_x,
    input  logic [9:0]  pac_y,
    input  logic [9:0]  red_x,
    input  logic [9:0]  red_y,
    input  logic [9:0]  blue_x,
    input  logic [9:0]  blue_y,
    input  logic [9:0]  green_x,
    input  logic [9:0]  green_y,
    input  logic [1:0]  pac_dir,
    input  logic        pac_moving,
    input  logic [3:0]  sprite_en,
    sprite_pixel_compositor_if.master rom,
    output logic [23:0] rgb,
    output logic        rgb_valid
);
    localparam int             AW        = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [AW-1:0]  ANIM_LAST = AW'(ANIM_FRAMES - 1);
    localparam logic [9:0]     W10       = 10'(SPRITE_W);
    localparam logic [9:0]     W_LAST    = 10'(SPRITE_W - 1);
    localparam logic [9:0]     H_LAST    = 10'(SPRITE_H - 1);
    localparam logic [10:0]    W11       = 11'(SPRITE_W);
    localparam logic [10:0]    H11       = 11'(SPRITE_H);

    logic [9:0]    lat_x [4];
    logic [9:0]    lat_y [4];
    logic [1:0]    lat_dir;
    logic [3:0]    lat_en;
    logic [AW-1:0] anim_cnt;
    logic          mouth_open;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                lat_x[i] <= '0;
                lat_y[i] <= '0;
            end
            lat_dir <= '0;
            lat_en  <= '0;
        end else if (frame_start) begin
            lat_x[0] <= pac_x;   lat_y[0] <= pac_y;
            lat_x[1] <= red_x;   lat_y[1] <= red_y;
            lat_x[2] <= blue_x;  lat_y[2] <= blue_y;
            lat_x[3] <= green_x; lat_y[3] <= green_y;
            lat_dir  <= pac_dir;
            lat_en   <= sprite_en;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            anim_cnt   <= '0;
            mouth_open <= 1'b1;
        end else if (frame_start) begin
            if (!pac_moving) begin
                anim_cnt   <= '0;
                mouth_open <= 1'b1;
            end else if (anim_cnt == ANIM_LAST) begin
                anim_cnt   <= '0;
                mouth_open <= ~mouth_open;
            end else begin
                anim_cnt <= anim_cnt + AW'(1);
            end
        end
    end

    logic [3:0] hit;
    logic [9:0] col [4];
    logic [9:0] row [4];
    logic [9:0] addr [4];
    logic [9:0] special_addr;

    // NOTE: every comb output gets a value on entry, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            col[i]  = DrawX - lat_x[i];
            row[i]  = DrawY - lat_y[i];
            hit[i]  = lat_en[i]
                   && ({1'b0, DrawX} >= {1'b0, lat_x[i]}) && ({1'b0, DrawX} < {1'b0, lat_x[i]} + W11)
                   && ({1'b0, DrawY} >= {1'b0, lat_y[i]}) && ({1'b0, DrawY} < {1'b0, lat_y[i]} + H11);
            addr[i] = hit[i] ? row[i] * W10 + col[i] : '0;
        end
        special_addr = addr[0];
        if (hit[0]) begin
            case (lat_dir)
                2'd2:    special_addr = row[0] * W10 + (W_LAST - col[0]);
                2'd3:    special_addr = (H_LAST - row[0]) * W10 + col[0];
                default: special_addr = addr[0];
            endcase
        end
    end

    assign rom.pac_man_cut_read_address          = addr[0];
    assign rom.pac_man_full_read_address_special = special_addr;
    assign rom.red_evil_read_address             = addr[1];
    assign rom.blue_evil_read_address            = addr[2];
    assign rom.green_evil_read_address           = addr[3];
    assign rom.direction = mouth_open ? {1'b0, lat_dir} : 3'b100;

    logic [3:0]  s1_hit;
    logic [23:0] s1_bg;
    logic        s1_valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_hit   <= '0;
            s1_bg    <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_hit   <= hit;
            s1_bg    <= background_rgb;
            s1_valid <= pix_valid;
        end
    end

    // Layers are applied lowest priority first; the last opaque one wins.
    logic [23:0] pix_next;
    always_comb begin
        pix_next = s1_bg;
        if (s1_hit[0] && rom.pac_man_cut_data_out != KEY_COLOR) pix_next = rom.pac_man_cut_data_out;
        if (s1_hit[3] && rom.green_evil_data_out  != KEY_COLOR) pix_next = rom.green_evil_data_out;
        if (s1_hit[2] && rom.blue_evil_data_out   != KEY_COLOR) pix_next = rom.blue_evil_data_out;
        if (s1_hit[1] && rom.red_evil_data_out    != KEY_COLOR) pix_next = rom.red_evil_data_out;
        if (!s1_valid) pix_next = '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= pix_next;
            rgb_valid <= s1_valid;
        end
    end
endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Self-checking bench: behavioural sprite model with a ROM stand-in,
// directed literal cases followed by randomized frames and a mid-stream reset.
module tb_sprite_pixel_compositor;
    localparam int          SW  = 26;
    localparam int          SH  = 26;
    localparam int          AF  = 8;
    localparam logic [23:0] KEY = 24'h000000;

    logic        Clk, Reset, frame_start, pix_valid, pac_moving;
    logic [9:0]  DrawX, DrawY;
    logic [9:0]  pac_x, pac_y, red_x, red_y, blue_x, blue_y, green_x, green_y;
    logic [1:0]  pac_dir;
    logic [3:0]  sprite_en;
    logic [23:0] background_rgb, rgb;
    logic        rgb_valid;
    logic [9:0]  pos_x [4];
    logic [9:0]  pos_y [4];

    assign pac_x = pos_x[0];   assign pac_y = pos_y[0];
    assign red_x = pos_x[1];   assign red_y = pos_y[1];
    assign blue_x = pos_x[2];  assign blue_y = pos_y[2];
    assign green_x = pos_x[3]; assign green_y = pos_y[3];

    sprite_pixel_compositor_if rom_if();

    sprite_pixel_compositor #(
        .SPRITE_W(SW), .SPRITE_H(SH), .ANIM_FRAMES(AF), .KEY_COLOR(KEY)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
        .background_rgb(background_rgb),
        .pac_x(pac_x), .pac_y(pac_y), .red_x(red_x), .red_y(red_y),
        .blue_x(blue_x), .blue_y(blue_y), .green_x(green_x), .green_y(green_y),
        .pac_dir(pac_dir), .pac_moving(pac_moving), .sprite_en(sprite_en),
        .rom(rom_if), .rgb(rgb), .rgb_valid(rgb_valid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: latched frame state and animation as plain integers.
    int          m_x [4];
    int          m_y [4];
    int          m_dir, m_cnt;
    bit [3:0]    m_en;
    bit          m_mouth;
    logic [24:0] exp_q [$];

    bit          fixed_mode;
    logic [23:0] fixed_data [4];

    function automatic logic [23:0] rom(input int s, input int a);
        int h;
        if (fixed_mode) return fixed_data[s];
        if ((a + 3 * s) % 4 == 0) return KEY;
        h = a * 2654435 + s * 40503 + 17;
        return h[23:0] | 24'h000001;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_x[s] = 0;
            m_y[s] = 0;
        end
        m_en = '0; m_dir = 0; m_cnt = 0; m_mouth = 1'b1;
        exp_q.delete();
    endtask

    task automatic model_advance();
        if (frame_start) begin
            for (int s = 0; s < 4; s++) begin
                m_x[s] = int'(pos_x[s]);
                m_y[s] = int'(pos_y[s]);
            end
            m_dir = int'(pac_dir);
            m_en  = sprite_en;
            if (pac_moving) begin
                m_cnt++;
                if (m_cnt == AF) begin
                    m_cnt   = 0;
                    m_mouth = !m_mouth;
                end
            end else begin
                m_cnt   = 0;
                m_mouth = 1'b1;
            end
        end
    endtask

    task automatic compare_cycle();
        int          ex_addr [4];
        bit [3:0]    ex_hit;
        logic [23:0] dat [4];
        logic [23:0] ex_rgb;
        logic [24:0] head;
        int          dx, dy, col0, row0, ex_spec, ex_dir;
        dx = int'(DrawX);
        dy = int'(DrawY);
        for (int s = 0; s < 4; s++) begin
            ex_hit[s]  = m_en[s] && dx >= m_x[s] && dx < m_x[s] + SW && dy >= m_y[s] && dy < m_y[s] + SH;
            ex_addr[s] = ex_hit[s] ? (dy - m_y[s]) * SW + (dx - m_x[s]) : 0;
            dat[s]     = rom(s, ex_addr[s]);
        end
        col0    = dx - m_x[0];
        row0    = dy - m_y[0];
        ex_spec = ex_addr[0];
        if (ex_hit[0] && m_dir == 2) ex_spec = row0 * SW + (SW - 1 - col0);
        if (ex_hit[0] && m_dir == 3) ex_spec = (SH - 1 - row0) * SW + col0;
        ex_dir = m_mouth ? m_dir : 4;

        check("cut_addr",   32'(rom_if.pac_man_cut_read_address),          32'(ex_addr[0]));
        check("spec_addr",  32'(rom_if.pac_man_full_read_address_special), 32'(ex_spec));
        check("red_addr",   32'(rom_if.red_evil_read_address),             32'(ex_addr[1]));
        check("blue_addr",  32'(rom_if.blue_evil_read_address),            32'(ex_addr[2]));
        check("green_addr", 32'(rom_if.green_evil_read_address),           32'(ex_addr[3]));
        check("direction",  32'(rom_if.direction),                         32'(ex_dir));

        if (exp_q.size() > 0) begin
            head = exp_q.pop_front();
            check("rgb",       32'(rgb),       32'(head[23:0]));
            check("rgb_valid", 32'(rgb_valid), 32'(head[24]));
        end

        if      (ex_hit[1] && dat[1] != KEY) ex_rgb = dat[1];
        else if (ex_hit[2] && dat[2] != KEY) ex_rgb = dat[2];
        else if (ex_hit[3] && dat[3] != KEY) ex_rgb = dat[3];
        else if (ex_hit[0] && dat[0] != KEY) ex_rgb = dat[0];
        else                                 ex_rgb = background_rgb;
        if (!pix_valid) ex_rgb = '0;
        exp_q.push_back({pix_valid, ex_rgb});
    endtask

    // One pixel cycle: compare at the falling edge, then answer the ROM reads.
    task automatic cycle();
        logic [9:0] a [4];
        @(negedge Clk);
        compare_cycle();
        model_advance();
        a[0] = rom_if.pac_man_cut_read_address;
        a[1] = rom_if.red_evil_read_address;
        a[2] = rom_if.blue_evil_read_address;
        a[3] = rom_if.green_evil_read_address;
        @(posedge Clk);
        #1;
        rom_if.pac_man_cut_data_out = rom(0, int'(a[0]));
        rom_if.red_evil_data_out    = rom(1, int'(a[1]));
        rom_if.blue_evil_data_out   = rom(2, int'(a[2]));
        rom_if.green_evil_data_out  = rom(3, int'(a[3]));
    endtask

    task automatic do_frame(input logic [3:0] en, input logic [1:0] dir, input logic moving);
        sprite_en   = en;
        pac_dir     = dir;
        pac_moving  = moving;
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic pixel_rgb(input string name, input int x, input int y,
                             input logic [23:0] bg, input logic [23:0] exp);
        DrawX = 10'(x); DrawY = 10'(y); background_rgb = bg; pix_valid = 1'b1;
        cycle();
        pix_valid = 1'b0; DrawX = '0; DrawY = '0;
        cycle();
        check(name, 32'(rgb), 32'(exp));
        check({name, "_valid"}, 32'(rgb_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"},   32'(rgb),       32'd0);
        check({tag, "_valid"}, 32'(rgb_valid), 32'd0);
        check({tag, "_dir"},   32'(rom_if.direction), 32'd0);
        check({tag, "_cut"},   32'(rom_if.pac_man_cut_read_address), 32'd0);
        check({tag, "_spec"},  32'(rom_if.pac_man_full_read_address_special), 32'd0);
        check({tag, "_red"},   32'(rom_if.red_evil_read_address), 32'd0);
        check({tag, "_blue"},  32'(rom_if.blue_evil_read_address), 32'd0);
        check({tag, "_green"}, 32'(rom_if.green_evil_read_address), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(25'd0);
        exp_q.push_back(25'd0);
    endtask

    initial begin
        int sp;
        Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pac_moving = 1'b0;
        DrawX = '0; DrawY = '0; background_rgb = '0; pac_dir = '0; sprite_en = '0;
        for (int s = 0; s < 4; s++) begin
            pos_x[s] = '0; pos_y[s] = '0; fixed_data[s] = '0;
        end
        fixed_mode = 1'b1;
        rom_if.pac_man_cut_data_out = '0; rom_if.red_evil_data_out = '0;
        rom_if.blue_evil_data_out = '0;   rom_if.green_evil_data_out = '0;
        model_reset();
        #2;
        check_reset_outputs("por");
        release_reset();

        // Addressing and Pac-Man image select.
        pos_x[0] = 10'd100; pos_y[0] = 10'd50;
        do_frame(4'b0001, 2'd0, 1'b0);
        DrawX = 10'd110; DrawY = 10'd60; pix_valid = 1'b1; background_rgb = 24'h2121DE;
        #2;
        check("addr_dir0_cut",  32'(rom_if.pac_man_cut_read_address), 32'd270);
        check("addr_dir0_spec", 32'(rom_if.pac_man_full_read_address_special), 32'd270);
        check("addr_dir0_sel",  32'(rom_if.direction), 32'b000);
        cycle();
        do_frame(4'b0001, 2'd2, 1'b0);
        #2;
        check("addr_dir2_spec", 32'(rom_if.pac_man_full_read_address_special), 32'd275);
        check("addr_dir2_sel",  32'(rom_if.direction), 32'b010);
        cycle();
        do_frame(4'b0001, 2'd3, 1'b0);
        #2;
        check("addr_dir3_spec", 32'(rom_if.pac_man_full_read_address_special), 32'd400);
        check("addr_dir3_sel",  32'(rom_if.direction), 32'b011);
        cycle();

        // Frame latch: positions only move on frame_start, and not in that same cycle.
        pos_x[0] = 10'd400;
        #2;
        check("latch_hold", 32'(rom_if.pac_man_cut_read_address), 32'd270);
        cycle();
        frame_start = 1'b1;
        #2;
        check("latch_same_cycle", 32'(rom_if.pac_man_cut_read_address), 32'd270);
        cycle();
        frame_start = 1'b0;
        #2;
        check("latch_new", 32'(rom_if.pac_man_cut_read_address), 32'd0);
        cycle();

        // Latency and colour-key transparency.
        fixed_data[1] = 24'hFF0000;
        pos_x[1] = 10'd200; pos_y[1] = 10'd200;
        do_frame(4'b0010, 2'd0, 1'b0);
        pixel_rgb("lat_red", 205, 205, 24'h2121DE, 24'hFF0000);
        fixed_data[1] = 24'h000000;
        pixel_rgb("key_red", 205, 205, 24'h2121DE, 24'h2121DE);

        // Layer priority.
        fixed_data[0] = 24'hFFFF00; fixed_data[1] = 24'hFF0000;
        fixed_data[2] = 24'h0000FF; fixed_data[3] = 24'h00FF00;
        for (int s = 0; s < 4; s++) begin
            pos_x[s] = 10'd300; pos_y[s] = 10'd300;
        end
        do_frame(4'b0111, 2'd0, 1'b0);
        pixel_rgb("prio_red", 310, 310, 24'h2121DE, 24'hFF0000);
        fixed_data[1] = 24'h000000;
        pixel_rgb("prio_blue", 310, 310, 24'h2121DE, 24'h0000FF);
        do_frame(4'b1001, 2'd0, 1'b0);
        pixel_rgb("prio_green", 310, 310, 24'h2121DE, 24'h00FF00);
        do_frame(4'b0001, 2'd0, 1'b0);
        pixel_rgb("prio_pac", 310, 310, 24'h2121DE, 24'hFFFF00);

        // Mouth animation.
        do_frame(4'b0001, 2'd0, 1'b0);
        #2;
        check("anim_idle", 32'(rom_if.direction), 32'b000);
        for (int k = 1; k <= 16; k++) begin
            do_frame(4'b0001, 2'd0, 1'b1);
            #2;
            check("anim_run", 32'(rom_if.direction), 32'((k >= 8 && k < 16) ? 3'b100 : 3'b000));
        end
        for (int k = 1; k <= 8; k++) do_frame(4'b0001, 2'd0, 1'b1);
        #2;
        check("anim_closed", 32'(rom_if.direction), 32'b100);
        do_frame(4'b0001, 2'd0, 1'b0);
        #2;
        check("anim_stop_open", 32'(rom_if.direction), 32'b000);
        for (int k = 1; k <= 7; k++) do_frame(4'b0001, 2'd0, 1'b1);
        #2;
        check("anim_cnt_cleared", 32'(rom_if.direction), 32'b000);
        do_frame(4'b0001, 2'd0, 1'b1);
        #2;
        check("anim_cnt_wrap", 32'(rom_if.direction), 32'b100);

        // Randomized frames with a hashed ROM, including a mid-stream reset.
        fixed_mode = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                #2;
                Reset = 1'b1;
                #1;
                check_reset_outputs("async");
                model_reset();
                release_reset();
            end
            frame_start = ($urandom_range(15) == 0);
            if (frame_start) begin
                for (int s = 0; s < 4; s++) begin
                    pos_x[s] = ($urandom_range(3) == 0) ? 10'($urandom_range(639, 600)) : 10'($urandom_range(639));
                    pos_y[s] = ($urandom_range(3) == 0) ? 10'($urandom_range(479, 440)) : 10'($urandom_range(479));
                end
                pac_dir    = 2'($urandom_range(3));
                sprite_en  = 4'($urandom_range(15));
                pac_moving = ($urandom_range(3) != 0);
            end
            sp = int'($urandom_range(3));
            DrawX = 10'(m_x[sp] + int'($urandom_range(31)) - 3);
            DrawY = 10'(m_y[sp] + int'($urandom_range(31)) - 3);
            pix_valid      = ($urandom_range(3) != 0);
            background_rgb = 24'($urandom);
            cycle();
        end

        frame_start = 1'b0;
        pix_valid   = 1'b0;
        for (int k = 0; k < 3; k++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sprite_pixel_compositor.md
# sprite_pixel_compositor

Per-pixel sprite front end and compositor for the VGA path. It converts the current draw coordinate into 10-bit read addresses for the 26x26 Pac-Man and ghost sprite ROMs and picks the Pac-Man facing/animation select. One cycle later it takes the 24-bit ROM pixels back, applies colour-key transparency and layer priority over the maze background, and emits the final registered RGB pixel. It also owns the per-frame position latch and the mouth open/close animation counter.

## Interface
- SPRITE_W, 26, sprite width in pixels
- SPRITE_H, 26, sprite height in pixels
- ANIM_FRAMES, 8, frames per mouth toggle (≥1)
- KEY_COLOR, 24'h000000, transparent colour in sprite ROM data

- Clk  in  1  system/pixel clock
- Reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blank
- DrawX, DrawY  in  10 each  current pixel coordinate
- pix_valid  in  1  DrawX/DrawY inside visible area
- background_rgb  in  24  maze colour for DrawX/DrawY, same cycle
- pac_x, pac_y, red_x, red_y, blue_x, blue_y, green_x, green_y  in  10 each  sprite top-left
- pac_dir  in  2  0 left, 1 down, 2 right, 3 up
- pac_moving  in  1  Pac-Man moved this frame
- sprite_en  in  4  {green, blue, red, pac} enables
- pac_man_cut_read_address, pac_man_full_read_address_special  out  10 each
- direction  out  3  Pac-Man ROM select
- red_evil_read_address, blue_evil_read_address, green_evil_read_address  out  10 each
- pac_man_cut_data_out, red_evil_data_out, blue_evil_data_out, green_evil_data_out  in  24 each  ROM data, one cycle after address
- rgb  out  24  composited pixel
- rgb_valid  out  1  rgb corresponds to a visible pixel

## Operation
- Frame latch: on a Clk edge with frame_start=1, capture all positions, pac_dir, and sprite_en. All address and hit logic uses only the latched values, so no tearing mid-frame.
- Hit test per sprite, computed in 11 bits with no wrap: hit = en && DrawX ≥ x && DrawX < x+SPRITE_W && DrawY ≥ y && DrawY < y+SPRITE_H.
- Offsets: col = DrawX−x, row = DrawY−y.
- Normal address: row*SPRITE_W+col, range 0..675.
- If a sprite is not hit, its address is 0.
- Special address (Pac-Man only):
  - latched dir 2: row*SPRITE_W+(SPRITE_W−1−col), horizontal mirror of the left image.
  - latched dir 3: (SPRITE_H−1−row)*SPRITE_W+col, vertical mirror of the down image.
  - otherwise equals the normal address.
- Animation state: mouth_open flag plus anim_cnt (width clog2(ANIM_FRAMES)).
  - On frame_start with pac_moving=1: if anim_cnt=ANIM_FRAMES−1, clear it and toggle mouth_open; else increment.
  - On frame_start with pac_moving=0: clear anim_cnt and set mouth_open=1.
- direction output:
  - mouth_open=0 → 3'b100.
  - Otherwise latched dir 0→000, 1→001, 2→010, 3→011.
- Address outputs and direction are combinational from DrawX/DrawY and latched state.
- Pipeline stage 1, registered each cycle: four hit flags, background_rgb, pix_valid.
- Pipeline stage 2, registered: a sprite is opaque if its hit flag is set and its ROM data ≠ KEY_COLOR.
  - Priority: red > blue > green > Pac-Man > background.
  - If the stage-1 valid flag is 0, rgb=0.
  - rgb_valid = stage-1 valid.

## Timing
- Reset asserts asynchronously and clears immediately:
  - latched state to 0: positions, dir, enables.
  - anim_cnt=0, mouth_open=1, all pipeline registers 0, rgb=0, rgb_valid=0.
  - Resulting outputs: direction=3'b000, all addresses 0.
- Latency: DrawX/DrawY/pix_valid at cycle N → ROM data at N+1 → rgb/rgb_valid at N+2. Fully pipelined, one pixel per cycle, no stalls.
- frame_start and a visible pixel in the same cycle: that pixel uses the old latched values; the new values apply from the next cycle.
- Reset deasserted mid-frame: outputs stay at reset values until pipeline data propagates (2 cycles). Sprites stay disabled until the first frame_start.
- A sprite at x ≥ 615 or y ≥ 455 that extends past 639/479 is clipped by the hit test. There is no address overflow beyond 675.

## Test plan
- Reset: assert Reset mid-stream → rgb=0, rgb_valid=0, direction=000, and all addresses 0 in the same cycle, without waiting for a Clk edge.
- Addressing: pac at (100,50), dir 0, enabled, frame_start. Then DrawX=110, DrawY=60 → cut address 270, special 270, direction 000. Same pixel with dir 2 → special 275, direction 010. With dir 3 → special 400, direction 011.
- Latency/transparency: red at (200,200) returns 24'hFF0000 at (205,205). Two cycles after input, rgb=FF0000, rgb_valid=1. Red data = 000000 with background 2121DE → rgb=2121DE.
- Priority: red, blue, and pac all at (300,300), all opaque → rgb = red data. Red transparent → blue data. Red and blue disabled → pac data.
- Animation: ANIM_FRAMES=8, pac_moving=1. After 8 frame_start pulses direction becomes 100; after 16 it returns to 00x. A pulse with pac_moving=0 → mouth_open=1 and anim_cnt=0.
- Frame latch: change pac_x mid-frame with no frame_start → addresses unchanged until the next frame_start.
